// File: rtl/sar_ctrl_param.sv
// sar_ctrl_param - parametrised SAR ADC conversion controller.
//
// Runs a SAMPLE_CYCLES-long sample phase (SAR_RESET high), then NBITS
// binary-search bit cycles, MSB first, driven by the comparator. The
// running trial code goes to the capacitive DAC. The one-hot bit enable
// goes to the per-bit logic. The finished code is registered on RESULT
// and announced by a one-cycle DONE pulse. The LSB decision is folded
// straight into RESULT, so no separate LSB latch is needed downstream.
//
// Build option:
//   SAR_CONT_CONV_EN  continuous mode. The controller leaves IDLE on its
//                     own after reset, always re-samples after DONE and
//                     ignores START.
//
// Parameters:
//   NBITS          resolution / number of bit cycles (2..16)
//   SAMPLE_CYCLES  length of the sample phase in cycles (1..15)
//
// Ports:
//   CLK        in   system clock, rising edge
//   RESET      in   synchronous active-high reset
//   START      in   conversion request, sampled in IDLE and DONE
//   VCOMP      in   comparator, 1 = Vin >= Vdac (keep trial bit)
//   SAR_RESET  out  high during SAMPLE
//   BUSY       out  high outside IDLE
//   BITEN      out  one-hot bit under test, zero outside CONVERT
//   DAC_CODE   out  decided bits OR trial bit, zero outside CONVERT
//   RESULT     out  last completed conversion
//   DONE       out  one-cycle pulse when RESULT takes a new value
//
// Every output is a flop, so no combinational path runs from VCOMP or
// START to any output.

module sar_ctrl_param #(
    parameter int NBITS         = 4,
    parameter int SAMPLE_CYCLES = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             VCOMP,
    output logic             SAR_RESET,
    output logic             BUSY,
    output logic [NBITS-1:0] BITEN,
    output logic [NBITS-1:0] DAC_CODE,
    output logic [NBITS-1:0] RESULT,
    output logic             DONE
);

    if (NBITS < 2 || NBITS > 16) begin : g_bad_nbits
        $fatal(1, "sar_ctrl_param: NBITS=%0d outside 2..16", NBITS);
    end
    if (SAMPLE_CYCLES < 1 || SAMPLE_CYCLES > 15) begin : g_bad_sample
        $fatal(1, "sar_ctrl_param: SAMPLE_CYCLES=%0d outside 1..15", SAMPLE_CYCLES);
    end

    // The sample counter needs at least one bit, even when SAMPLE_CYCLES is 1.
    localparam int CW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam int KW = $clog2(NBITS);

    localparam logic [CW-1:0]    CNT_LAST = CW'(SAMPLE_CYCLES - 1);
    localparam logic [KW-1:0]    K_TOP    = KW'(NBITS - 1);
    localparam logic [NBITS-1:0] ONE      = NBITS'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SAMPLE  = 2'd1,
        S_CONVERT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [KW-1:0]    k;
    logic [NBITS-1:0] work;
    logic [NBITS-1:0] work_nx;
    logic             go;

`ifdef SAR_CONT_CONV_EN
    // START is ignored in this mode. It is still referenced so the port
    // stays connected.
    assign go = START | 1'b1;
`else
    assign go = START;
`endif

    // Working register with the bit under test replaced by the comparator decision.
    always_comb begin
        work_nx    = work;
        work_nx[k] = VCOMP;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_IDLE;
            cnt       <= '0;
            k         <= '0;
            work      <= '0;
            SAR_RESET <= 1'b0;
            BUSY      <= 1'b0;
            BITEN     <= '0;
            DAC_CODE  <= '0;
            RESULT    <= '0;
            DONE      <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        state     <= S_SAMPLE;
                        cnt       <= '0;
                        work      <= '0;
                        SAR_RESET <= 1'b1;
                        BUSY      <= 1'b1;
                    end
                end
                S_SAMPLE: begin
                    work <= '0;
                    if (cnt == CNT_LAST) begin
                        state     <= S_CONVERT;
                        k         <= K_TOP;
                        SAR_RESET <= 1'b0;
                        BITEN     <= ONE << K_TOP;
                        DAC_CODE  <= ONE << K_TOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_CONVERT: begin
                    work <= work_nx;
                    if (k == '0) begin
                        // The LSB decision goes directly into RESULT.
                        state    <= S_DONE;
                        RESULT   <= work_nx;
                        BITEN    <= '0;
                        DAC_CODE <= '0;
                        DONE     <= 1'b1;
                    end else begin
                        k        <= k - 1'b1;
                        BITEN    <= ONE << (k - 1'b1);
                        DAC_CODE <= work_nx | (ONE << (k - 1'b1));
                    end
                end
                S_DONE: begin
                    if (go) begin
                        state     <= S_SAMPLE;
                        cnt       <= '0;
                        work      <= '0;
                        SAR_RESET <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    SAR_RESET <= 1'b0;
                    BUSY      <= 1'b0;
                    BITEN     <= '0;
                    DAC_CODE  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_ctrl_param.sv
// tb_sar_ctrl_param - directed bench for sar_ctrl_param.
// Instantiates a 4-bit / 1-sample-cycle controller and an 8-bit /
// 3-sample-cycle controller. Each controller has an ideal comparator
// model (VCOMP = Vin >= DAC_CODE).

module tb_sar_ctrl_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start8;
    logic [3:0] vin;
    logic [7:0] vin8;

    logic       vcomp, sar_reset, busy, done;
    logic [3:0] biten, dac, result;
    logic       vcomp8, sar_reset8, busy8, done8;
    logic [7:0] biten8, dac8, result8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign vcomp  = (vin >= dac);
    assign vcomp8 = (vin8 >= dac8);

    sar_ctrl_param #(.NBITS(4), .SAMPLE_CYCLES(1)) dut4 (
        .CLK(clk), .RESET(rst), .START(start), .VCOMP(vcomp),
        .SAR_RESET(sar_reset), .BUSY(busy), .BITEN(biten),
        .DAC_CODE(dac), .RESULT(result), .DONE(done)
    );

    sar_ctrl_param #(.NBITS(8), .SAMPLE_CYCLES(3)) dut8 (
        .CLK(clk), .RESET(rst), .START(start8), .VCOMP(vcomp8),
        .SAR_RESET(sar_reset8), .BUSY(busy8), .BITEN(biten8),
        .DAC_CODE(dac8), .RESULT(result8), .DONE(done8)
    );

    typedef struct {
        logic [3:0]  vin;
        logic [15:0] dac_seq;   // four trial codes, first one in the top nibble
        logic [3:0]  res;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [3:0] prev;
        int         ndone;
        bit         found;

        vecs[0] = '{vin: 4'd11, dac_seq: 16'h8CAB, res: 4'b1011};
        vecs[1] = '{vin: 4'd0,  dac_seq: 16'h8421, res: 4'b0000};
        vecs[2] = '{vin: 4'd15, dac_seq: 16'h8CEF, res: 4'b1111};
        vecs[3] = '{vin: 4'd5,  dac_seq: 16'h8465, res: 4'b0101};
        vecs[4] = '{vin: 4'd10, dac_seq: 16'h8CAB, res: 4'b1010};

        rst = 1'b1; start = 1'b0; start8 = 1'b0; vin = '0; vin8 = '0;
        tick(); tick();
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_sar_reset", 32'(sar_reset), 32'd0);
        chk("rst_biten",     32'(biten),     32'd0);
        chk("rst_dac",       32'(dac),       32'd0);
        chk("rst_result",    32'(result),    32'd0);
        chk("rst_done",      32'(done),      32'd0);
        rst = 1'b0;

`ifdef SAR_CONT_CONV_EN
        vin = 4'd6;
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            tick();
            found = done;
        end
        chk("cont_first_done", 32'(found), 32'd1);
        chk("cont_result0",    32'(result), 32'd6);
        for (int r = 0; r < 3; r++) begin
            for (int c = 1; c <= 6; c++) begin
                tick();
                chk("cont_busy", 32'(busy), 32'd1);
                chk("cont_done", 32'(done), 32'(c == 6));
            end
            chk("cont_result", 32'(result), 32'd6);
        end
`else
        // Single conversions from the table.
        prev = 4'd0;
        for (int i = 0; i < 5; i++) begin
            vin = vecs[i].vin;
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("sample_sar_reset", 32'(sar_reset), 32'd1);
            chk("sample_busy",      32'(busy),      32'd1);
            chk("sample_biten",     32'(biten),     32'd0);
            for (int b = 0; b < 4; b++) begin
                tick();
                chk("conv_biten",     32'(biten),     32'(4'b1000 >> b));
                chk("conv_dac",       32'(dac),       32'(vecs[i].dac_seq[15-4*b -: 4]));
                chk("conv_result_hold", 32'(result),  32'(prev));
                chk("conv_done",      32'(done),      32'd0);
                chk("conv_sar_reset", 32'(sar_reset), 32'd0);
            end
            tick();
            chk("done_pulse",  32'(done),   32'd1);
            chk("done_result", 32'(result), 32'(vecs[i].res));
            chk("done_busy",   32'(busy),   32'd1);
            chk("done_biten",  32'(biten),  32'd0);
            tick();
            chk("idle_done",   32'(done),   32'd0);
            chk("idle_busy",   32'(busy),   32'd0);
            chk("idle_result", 32'(result), 32'(vecs[i].res));
            prev = vecs[i].res;
        end

        // START held high: back-to-back conversions, DONE every 6 cycles.
        vin = 4'd11;
        start = 1'b1;
        tick();
        for (int t = 1; t <= 17; t++) begin
            if (t == 17) start = 1'b0;
            tick();
            chk("b2b_done", 32'(done), 32'((t % 6) == 5));
            if ((t % 6) == 5) chk("b2b_result", 32'(result), 32'd11);
        end
        tick();
        chk("b2b_idle_busy", 32'(busy), 32'd0);

        // START pulses during CONVERT add no conversion.
        vin = 4'd5;
        start = 1'b1;
        tick();
        ndone = 0;
        for (int t = 1; t <= 12; t++) begin
            start = (t == 2 || t == 4);
            tick();
            chk("ign_done", 32'(done), 32'(t == 5));
            if (done) ndone++;
        end
        start = 1'b0;
        chk("ign_ndone",  32'(ndone),  32'd1);
        chk("ign_busy",   32'(busy),   32'd0);
        chk("ign_result", 32'(result), 32'd5);

        // RESET during bit 2 discards the conversion.
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst2_result", 32'(result), 32'd0);
        vin = 4'd11;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        chk("bit2_biten", 32'(biten), 32'b0100);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("abort_busy",      32'(busy),      32'd0);
        chk("abort_biten",     32'(biten),     32'd0);
        chk("abort_dac",       32'(dac),       32'd0);
        chk("abort_sar_reset", 32'(sar_reset), 32'd0);
        chk("abort_done",      32'(done),      32'd0);
        for (int t = 0; t < 8; t++) begin
            tick();
            chk("abort_no_done", 32'(done),   32'd0);
            chk("abort_result",  32'(result), 32'd0);
            chk("abort_idle",    32'(busy),   32'd0);
        end

        // RESET and START together: RESET wins.
        rst = 1'b1; start = 1'b1; tick(); rst = 1'b0; start = 1'b0;
        chk("rs_busy",      32'(busy),      32'd0);
        chk("rs_sar_reset", 32'(sar_reset), 32'd0);
        tick();
        chk("rs_stay_idle", 32'(busy), 32'd0);

        // 8-bit / 3 sample cycles, Vin = 0xA5.
        vin8 = 8'hA5;
        start8 = 1'b1; tick(); start8 = 1'b0;
        chk("w8_sar_reset0", 32'(sar_reset8), 32'd1);
        for (int t = 1; t <= 11; t++) begin
            tick();
            chk("w8_sar_reset", 32'(sar_reset8), 32'(t < 3));
            chk("w8_done",      32'(done8),      32'(t == 11));
        end
        chk("w8_result", 32'(result8), 32'hA5);
        tick();
        chk("w8_idle", 32'(busy8), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
